hs_decimate2: RTL and testbench
===============================

HS_DECIMATE2 -- requirements
Module: hs_decimate2

Interface
REQ-001 SHALL have parameter DW, default 8: sample width in bits, two's complement.
REQ-002 SHALL have parameter DEPTH, default 4: output FIFO entries; power of 2, minimum 2.
REQ-003 SHALL have parameter KEEP_PHASE, default 0: input phase (0/1) retained by the decimator.
REQ-004 SHALL have port i_clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port i_reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port i_ce, input, 1: input sample strobe from the upstream half-band FIR output.
REQ-007 SHALL have port i_data, input, DW: filtered sample, valid when i_ce=1.
REQ-008 SHALL have port o_valid, output, 1: o_data holds a valid decimated sample.
REQ-009 SHALL have port i_ready, input, 1: downstream accepts o_data this cycle.
REQ-010 SHALL have port o_data, output, DW: FIFO head sample.
REQ-011 SHALL have port o_count, output, $clog2(DEPTH)+1: FIFO occupancy, 0..DEPTH.
REQ-012 SHALL have port o_overflow, output, 1: sticky flag; a kept sample was dropped.

Function
REQ-013 SHALL hold a phase bit that toggles on every cycle with i_ce=1 and holds otherwise.
REQ-014 SHALL mark a sample as kept when i_ce=1 and phase==KEEP_PHASE (pre-toggle value); other samples are discarded silently.
REQ-015 SHALL push: kept sample written at wr_ptr when count<DEPTH, or when count==DEPTH with a pop in the same cycle.
REQ-016 SHALL pop on o_valid && i_ready; i_ready while o_valid=0 has no effect.
REQ-017 SHALL update count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop (including at empty: count 0, push wins, pop impossible).
REQ-018 SHALL assert o_valid exactly when count>0; a sample kept in cycle N appears on o_data with o_valid=1 in cycle N+1 at the earliest.
REQ-019 SHALL drive o_data = mem[rd_ptr] when o_valid=1, else 0.
REQ-020 SHALL wrap wr_ptr/rd_ptr modulo DEPTH with no bubble.
REQ-021 SHALL drop a kept sample arriving when count==DEPTH with no pop, and set o_overflow=1 the next cycle; o_overflow clears only on reset.
REQ-022 SHALL preserve sample order; no arithmetic is performed on data (bit-exact passthrough of kept samples).

Reset
REQ-023 SHALL, on i_clk edge with i_reset=1, clear phase, wr_ptr, rd_ptr, count, o_overflow; o_valid=0, o_data=0, o_count=0 the following cycle.
REQ-024 SHALL ignore i_ce/i_ready during reset cycles; FIFO memory is not cleared, but its contents are unobservable until rewritten.
REQ-025 SHALL treat reset mid-stream as discarding all queued samples; the first i_ce after release is phase 0.

Configuration
REQ-026 SHALL, with HSDEC_OVF_COUNT_EN defined, add output o_ovf_cnt (8 bits): count of dropped samples, saturating at 255, cleared by reset.
REQ-027 SHALL, without HSDEC_OVF_COUNT_EN, omit o_ovf_cnt and its logic; all other behaviour identical.

Verification
REQ-028 SHALL cover: reset, then i_ce=1 continuously with i_data=1,2,3,4,5,6, i_ready=1, KEEP_PHASE=0 -> o_data sequence 1,3,5, each with o_valid=1 one cycle after its input.
REQ-029 SHALL cover: KEEP_PHASE=1, same stimulus -> 2,4,6.
REQ-030 SHALL cover: i_ready=0, 12 consecutive strobes with values 10..21 -> o_count reaches 4 holding 10,12,14,16; 18 and 20 dropped; o_overflow=1; o_ovf_cnt=2 when enabled; then i_ready=1 drains 10,12,14,16.
REQ-031 SHALL cover: FIFO full, i_ready=1, and a kept sample 0x7F in the same cycle -> o_count stays 4, 0x7F is queued, o_overflow unchanged.
REQ-032 SHALL cover: i_ce gapped (1,0,0,1,0,1) with data A,-,-,B,-,C -> A and C kept; phase unaffected by idle cycles.
REQ-033 SHALL cover: reset asserted with o_count=3 -> next cycle o_valid=0, o_count=0, o_overflow=0; next strobe 0x55 kept and output.

Source files
------------

// File: rtl/hs_decimate2.sv
// -----------------------------------------------------------------------------
// hs_decimate2 -- decimate-by-2 stage behind a half-band FIR, with output FIFO.
//
// Every i_ce strobe toggles a phase bit. A strobe arriving while the phase
// equals KEEP_PHASE is kept and queued into a DEPTH-entry FIFO. Other strobes
// are discarded. Kept data passes through bit-exact and in order.
//
// Parameters
//   DW          sample width (two's complement)
//   DEPTH       FIFO entries, power of 2, >= 2
//   KEEP_PHASE  phase (0/1) whose samples are retained
//
// Ports
//   i_clk       clock, all state on rising edge
//   i_reset     synchronous active-high reset
//   i_ce        input sample strobe
//   i_data      input sample, valid with i_ce
//   o_valid     o_data holds a queued sample (count > 0)
//   i_ready     downstream accepts o_data this cycle
//   o_data      FIFO head, 0 when empty
//   o_count     FIFO occupancy, 0..DEPTH
//   o_overflow  sticky: a kept sample was dropped on a full FIFO
//   o_ovf_cnt   (HSDEC_OVF_COUNT_EN only) dropped-sample count, saturates at 255
//
// Optional feature macro: HSDEC_OVF_COUNT_EN
// -----------------------------------------------------------------------------
module hs_decimate2 #(
    parameter int DW         = 8,
    parameter int DEPTH      = 4,
    parameter int KEEP_PHASE = 0
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_ce,
    input  logic [DW-1:0]            i_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [DW-1:0]            o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow
`ifdef HSDEC_OVF_COUNT_EN
    ,
    output logic [7:0]               o_ovf_cnt
`endif
);

    localparam int             AW       = $clog2(DEPTH);
    localparam int             CW       = AW + 1;
    localparam logic [CW-1:0]  FULL     = CW'(DEPTH);
    localparam logic           KEEP_BIT = (KEEP_PHASE != 0);

    logic [DW-1:0] mem [DEPTH];

    logic          phase_q,    phase_d;
    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0] count_q,    count_d;
    logic          overflow_q, overflow_d;

    logic keep;
    logic pop;
    logic push;
    logic drop;

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        keep       = i_ce && (phase_q == KEEP_BIT);
        pop        = (count_q != '0) && i_ready;
        // A full FIFO still accepts a kept sample when the head leaves the
        // same cycle.
        push       = keep && ((count_q != FULL) || pop);
        drop       = keep && !push;

        phase_d    = phase_q ^ i_ce;
        // DEPTH is a power of two, so pointer wrap is the natural rollover.
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        overflow_d = overflow_q | drop;

        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            phase_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the sample memory has no reset; entries are only visible through
    // count_q, which is cleared, so stale contents can never reach o_data.
    always_ff @(posedge i_clk) begin
        if (!i_reset && push) begin
            mem[wr_ptr_q] <= i_data;
        end
    end

    assign o_valid    = (count_q != '0);
    assign o_data     = o_valid ? mem[rd_ptr_q] : '0;
    assign o_count    = count_q;
    assign o_overflow = overflow_q;

`ifdef HSDEC_OVF_COUNT_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (drop && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_d = ovf_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ovf_cnt_q <= 8'd0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign o_ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_hs_decimate2.sv
// -----------------------------------------------------------------------------
// tb_hs_decimate2 -- self-checking bench for hs_decimate2.
//
// Two instances share one stimulus stream: KEEP_PHASE=0 (index 0) and
// KEEP_PHASE=1 (index 1). A queue-style model (list with shift-out on pop)
// predicts occupancy, head data and overflow state; a negedge process compares
// both instances against it every cycle. Directed scenarios add literal
// expectations on the model's popped-sample log and on key DUT outputs.
// -----------------------------------------------------------------------------
module tb_hs_decimate2;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_ce;
    logic [DW-1:0] i_data;
    logic          i_ready;

    logic          o_valid    [2];
    logic [DW-1:0] o_data     [2];
    logic [2:0]    o_count    [2];
    logic          o_overflow [2];
`ifdef HSDEC_OVF_COUNT_EN
    logic [7:0]    o_ovf_cnt  [2];
`endif

    always #5 clk = ~clk;

    hs_decimate2 #(.DW(DW), .DEPTH(DEPTH), .KEEP_PHASE(0)) dut0 (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_ce       (i_ce),
        .i_data     (i_data),
        .o_valid    (o_valid[0]),
        .i_ready    (i_ready),
        .o_data     (o_data[0]),
        .o_count    (o_count[0]),
        .o_overflow (o_overflow[0])
`ifdef HSDEC_OVF_COUNT_EN
        ,
        .o_ovf_cnt  (o_ovf_cnt[0])
`endif
    );

    hs_decimate2 #(.DW(DW), .DEPTH(DEPTH), .KEEP_PHASE(1)) dut1 (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_ce       (i_ce),
        .i_data     (i_data),
        .o_valid    (o_valid[1]),
        .i_ready    (i_ready),
        .o_data     (o_data[1]),
        .o_count    (o_count[1]),
        .o_overflow (o_overflow[1])
`ifdef HSDEC_OVF_COUNT_EN
        ,
        .o_ovf_cnt  (o_ovf_cnt[1])
`endif
    );

    // ---------------- model ----------------
    int            n_vec  = 0;
    int            n_fail = 0;
    bit            chk_en = 1'b0;

    int            strobes;           // strobes since reset: even -> phase 0
    logic [DW-1:0] mlist [2][0:7];    // queued samples, head at index 0
    int            msize [2];
    bit            movf  [2];
    int            mdrops[2];
    logic [DW-1:0] plog0 [$];         // samples the model saw leave each FIFO
    logic [DW-1:0] plog1 [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic rst, input logic ce, input logic [DW-1:0] d,
                                input logic rdy);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                msize[k]  = 0;
                movf[k]   = 1'b0;
                mdrops[k] = 0;
            end else begin
                if (msize[k] > 0 && rdy) begin
                    if (k == 0) plog0.push_back(mlist[k][0]);
                    else        plog1.push_back(mlist[k][0]);
                    for (int j = 0; j < 7; j++) mlist[k][j] = mlist[k][j+1];
                    msize[k]--;
                end
                if (ce && ((strobes % 2) == k)) begin
                    if (msize[k] < DEPTH) begin
                        mlist[k][msize[k]] = d;
                        msize[k]++;
                    end else begin
                        movf[k] = 1'b1;
                        if (mdrops[k] < 255) mdrops[k]++;
                    end
                end
            end
        end
        if (rst)     strobes = 0;
        else if (ce) strobes++;
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("valid[%0d]", k), 32'(o_valid[k]), 32'(msize[k] > 0));
                check($sformatf("data[%0d]", k), 32'(o_data[k]),
                      (msize[k] > 0) ? 32'(mlist[k][0]) : 32'd0);
                check($sformatf("count[%0d]", k), 32'(o_count[k]), 32'(msize[k]));
                check($sformatf("overflow[%0d]", k), 32'(o_overflow[k]), 32'(movf[k]));
`ifdef HSDEC_OVF_COUNT_EN
                check($sformatf("ovf_cnt[%0d]", k), 32'(o_ovf_cnt[k]), 32'(mdrops[k]));
`endif
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input logic rst, input logic ce, input logic [DW-1:0] d, input logic rdy);
        i_reset = rst;
        i_ce    = ce;
        i_data  = d;
        i_ready = rdy;
        @(posedge clk);
        model_update(rst, ce, d, rdy);
        #1;
    endtask

    task automatic clear_logs();
        plog0.delete();
        plog1.delete();
    endtask

    task automatic check_log(input string nm, input int k, input int n,
                             input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                             input logic [DW-1:0] e2, input logic [DW-1:0] e3);
        logic [DW-1:0] e [4];
        int            sz;
        e = '{e0, e1, e2, e3};
        sz = (k == 0) ? plog0.size() : plog1.size();
        check({nm, "_len"}, 32'(sz), 32'(n));
        for (int i = 0; i < n && i < sz; i++) begin
            check($sformatf("%s_%0d", nm, i), (k == 0) ? 32'(plog0[i]) : 32'(plog1[i]), 32'(e[i]));
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        strobes = 0;
        msize   = '{0, 0};
        movf    = '{1'b0, 1'b0};
        mdrops  = '{0, 0};

        // Reset with strobes/ready active: both must be ignored.
        cyc(1'b1, 1'b1, 8'hAA, 1'b1);
        cyc(1'b1, 1'b1, 8'hBB, 1'b1);
        chk_en = 1'b1;
        check("rst_valid", 32'(o_valid[0]), 32'd0);
        check("rst_count", 32'(o_count[0]), 32'd0);
        check("rst_data",  32'(o_data[0]),  32'd0);

        // Continuous strobes 1..6, ready=1: phase 0 -> 1,3,5; phase 1 -> 2,4,6.
        clear_logs();
        for (int i = 1; i <= 6; i++) begin
            cyc(1'b0, 1'b1, 8'(i), 1'b1);
            if (i == 1) begin
                check("t1_first_valid", 32'(o_valid[0]), 32'd1);
                check("t1_first_data",  32'(o_data[0]),  32'd1);
                check("t1_k1_empty",    32'(o_valid[1]), 32'd0);
            end
        end
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        check_log("t1_k0", 0, 3, 8'd1, 8'd3, 8'd5, 8'd0);
        check_log("t1_k1", 1, 3, 8'd2, 8'd4, 8'd6, 8'd0);

        // Backpressure: 12 strobes 10..21 with ready=0, then drain.
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 10; i <= 21; i++) cyc(1'b0, 1'b1, 8'(i), 1'b0);
        check("t2_count", 32'(o_count[0]), 32'd4);
        check("t2_ovf",   32'(o_overflow[0]), 32'd1);
        check("t2_head",  32'(o_data[0]), 32'd10);
`ifdef HSDEC_OVF_COUNT_EN
        check("t2_ovf_cnt", 32'(o_ovf_cnt[0]), 32'd2);
`endif
        clear_logs();
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1);
        check_log("t2_k0", 0, 4, 8'd10, 8'd12, 8'd14, 8'd16);
        check_log("t2_k1", 1, 4, 8'd11, 8'd13, 8'd15, 8'd17);
        check("t2_sticky", 32'(o_overflow[0]), 32'd1);

        // Full FIFO with simultaneous pop and kept 0x7F.
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 30; i <= 37; i++) cyc(1'b0, 1'b1, 8'(i), 1'b0);
        check("t3_full", 32'(o_count[0]), 32'd4);
        cyc(1'b0, 1'b1, 8'h7F, 1'b1);
        check("t3_count", 32'(o_count[0]), 32'd4);
        check("t3_ovf",   32'(o_overflow[0]), 32'd0);
        check("t3_k1_count", 32'(o_count[1]), 32'd3);
        clear_logs();
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1);
        check_log("t3_k0", 0, 4, 8'd32, 8'd34, 8'd36, 8'h7F);

        // Gapped strobes A,-,-,B,-,C: idle cycles do not advance phase.
        cyc(1'b1, 1'b0, 8'h00, 1'b1);
        clear_logs();
        cyc(1'b0, 1'b1, 8'h11, 1'b1);
        cyc(1'b0, 1'b0, 8'hEE, 1'b1);
        cyc(1'b0, 1'b0, 8'hEE, 1'b1);
        cyc(1'b0, 1'b1, 8'h22, 1'b1);
        cyc(1'b0, 1'b0, 8'hEE, 1'b1);
        cyc(1'b0, 1'b1, 8'hC3, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        check_log("t4_k0", 0, 2, 8'h11, 8'hC3, 8'h00, 8'h00);
        check_log("t4_k1", 1, 1, 8'h22, 8'h00, 8'h00, 8'h00);

        // Reset mid-stream with three samples queued.
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 40; i <= 45; i++) cyc(1'b0, 1'b1, 8'(i), 1'b0);
        check("t5_count3", 32'(o_count[0]), 32'd3);
        cyc(1'b1, 1'b1, 8'h99, 1'b1);
        check("t5_valid", 32'(o_valid[0]), 32'd0);
        check("t5_count", 32'(o_count[0]), 32'd0);
        check("t5_ovf",   32'(o_overflow[0]), 32'd0);
        clear_logs();
        cyc(1'b0, 1'b1, 8'h55, 1'b1);
        check("t5_valid_after", 32'(o_valid[0]), 32'd1);
        check("t5_data_after",  32'(o_data[0]),  32'h55);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        check_log("t5_k0", 0, 1, 8'h55, 8'h00, 8'h00, 8'h00);
        check_log("t5_k1", 1, 0, 8'h00, 8'h00, 8'h00, 8'h00);

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
